openrigil_reset_sequencer: RTL and testbench

OPENRIGIL_RESET_SEQUENCER -- requirements
Module: openrigil_reset_sequencer

---
 rtl/openrigil_reset_sequencer.sv | 150 +++++++++++++++
 tb/tb_openrigil_reset_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/openrigil_reset_sequencer.sv
// Board/software/watchdog reset sequencer: synchronises and debounces the pin, holds reset, then releases domains in a staggered order.
// Latency: outputs are registered; a source seen on one edge asserts all domains on the next. No backpressure; all ports are levels or single-cycle pulses.
module openrigil_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int NUM_DOMAINS     = 3,
  parameter int STAGGER_CYCLES  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   nreset_pin,
  input  logic                   sw_reset_req,
  input  logic                   wdt_expire,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   rst_active,
  output logic [1:0]             rst_cause,
  output logic [7:0]             reset_count
);

  localparam int DB_W   = $clog2(65535 + 1);
  localparam int HOLD_W = $clog2(65535 + 1);
  localparam int STG_W  = $clog2(255 + 1);

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_PIN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   deb_q, deb_d;
  logic [DB_W-1:0]        deb_cnt_q, deb_cnt_d, deb_cnt_inc;
  logic [1:0]             state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [STG_W-1:0]       stg_cnt_q, stg_cnt_d;
  logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d, rst_shift;
  logic                   rst_active_q, rst_active_d;
  logic [1:0]             rst_cause_q, rst_cause_d, cause_sel;
  logic [7:0]             reset_count_q, reset_count_d;
  logic                   pin_sample, pin_req, src;

  // Pin synchroniser and debouncer
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], nreset_pin};
    pin_sample  = sync_q[SYNC_STAGES-1];
    deb_cnt_inc = deb_cnt_q + DB_W'(1);
    deb_d       = deb_q;
    deb_cnt_d   = '0;
    if (pin_sample != deb_q) begin
      if (deb_cnt_inc == DB_W'(DEBOUNCE_CYCLES)) begin
        deb_d     = pin_sample;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_inc;
      end
    end
  end

  assign pin_req   = ~deb_q;
  assign src       = pin_req | sw_reset_req | wdt_expire;
  assign cause_sel = pin_req ? CAUSE_PIN : (wdt_expire ? CAUSE_WDT : CAUSE_SW);
  // Domains release low bit first, so each release step is a left shift of the mask.
  assign rst_shift = rst_out_q << 1;

  always_comb begin
    state_d       = state_q;
    rst_out_d     = rst_out_q;
    hold_cnt_d    = hold_cnt_q;
    stg_cnt_d     = stg_cnt_q;
    rst_cause_d   = rst_cause_q;
    reset_count_d = reset_count_q;
    case (state_q)
      ST_ASSERT: begin
        rst_out_d = '1;
        stg_cnt_d = '0;
        if (src) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          hold_cnt_d = '0;
          rst_out_d  = {NUM_DOMAINS{1'b1}} << 1;
          state_d    = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RELEASE, ST_RUN: begin
        if (src) begin
          state_d     = ST_ASSERT;
          rst_out_d   = '1;
          hold_cnt_d  = '0;
          stg_cnt_d   = '0;
          rst_cause_d = cause_sel;
          if (reset_count_q != 8'hFF) reset_count_d = reset_count_q + 8'd1;
        end else if (state_q == ST_RELEASE) begin
          if (stg_cnt_q == STG_W'(STAGGER_CYCLES - 1)) begin
            stg_cnt_d = '0;
            rst_out_d = rst_shift;
            if (rst_shift == '0) state_d = ST_RUN;
          end else begin
            stg_cnt_d = stg_cnt_q + STG_W'(1);
          end
        end
      end
      default: begin
        state_d    = ST_ASSERT;
        rst_out_d  = '1;
        hold_cnt_d = '0;
        stg_cnt_d  = '0;
      end
    endcase
  end

  assign rst_active_d = (state_d != ST_RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q        <= '1;
      deb_q         <= 1'b1;
      deb_cnt_q     <= '0;
      state_q       <= ST_ASSERT;
      hold_cnt_q    <= '0;
      stg_cnt_q     <= '0;
      rst_out_q     <= '1;
      rst_active_q  <= 1'b1;
      rst_cause_q   <= CAUSE_POR;
      reset_count_q <= '0;
    end else begin
      sync_q        <= sync_d;
      deb_q         <= deb_d;
      deb_cnt_q     <= deb_cnt_d;
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      stg_cnt_q     <= stg_cnt_d;
      rst_out_q     <= rst_out_d;
      rst_active_q  <= rst_active_d;
      rst_cause_q   <= rst_cause_d;
      reset_count_q <= reset_count_d;
    end
  end

  assign rst_out     = rst_out_q;
  assign rst_active  = rst_active_q;
  assign rst_cause   = rst_cause_q;
  assign reset_count = reset_count_q;

endmodule

// File: tb/tb_openrigil_reset_sequencer.sv
// Directed bench for openrigil_reset_sequencer at default parameters.
module tb_openrigil_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       nreset_pin;
  logic       sw_reset_req;
  logic       wdt_expire;
  logic [2:0] rst_out;
  logic       rst_active;
  logic [1:0] rst_cause;
  logic [7:0] reset_count;

  int checks = 0;
  int failures = 0;

  openrigil_reset_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .nreset_pin   (nreset_pin),
    .sw_reset_req (sw_reset_req),
    .wdt_expire   (wdt_expire),
    .rst_out      (rst_out),
    .rst_active   (rst_active),
    .rst_cause    (rst_cause),
    .reset_count  (reset_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    int         n;
    logic       rst;
    logic       pin;
    logic       sw;
    logic       wdt;
    logic [2:0] eo;
    logic       ea;
    logic [1:0] ec;
    logic [7:0] en;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, int n, logic rst, logic pin, logic sw, logic wdt,
                              logic [2:0] eo, logic ea, logic [1:0] ec, logic [7:0] en);
    vec_t v;
    v.name = name; v.n = n; v.rst = rst; v.pin = pin; v.sw = sw; v.wdt = wdt;
    v.eo = eo; v.ea = ea; v.ec = ec; v.en = en;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [2:0] eo, input logic ea,
                         input logic [1:0] ec, input logic [7:0] en);
    chk({nm, ".rst_out"}, {5'd0, rst_out}, {5'd0, eo});
    chk({nm, ".rst_active"}, {7'd0, rst_active}, {7'd0, ea});
    chk({nm, ".rst_cause"}, {6'd0, rst_cause}, {6'd0, ec});
    chk({nm, ".reset_count"}, reset_count, en);
  endtask

  initial begin
    //                 name          n  rst pin sw wdt  out     act cause  count
    tbl.push_back(mk("por_hold",     3, 1, 1, 0, 0, 3'b111, 1, 2'b00, 8'd0));
    tbl.push_back(mk("por_c7",       7, 0, 1, 0, 0, 3'b111, 1, 2'b00, 8'd0));
    tbl.push_back(mk("por_c8",       1, 0, 1, 0, 0, 3'b110, 1, 2'b00, 8'd0));
    tbl.push_back(mk("por_c11",      3, 0, 1, 0, 0, 3'b110, 1, 2'b00, 8'd0));
    tbl.push_back(mk("por_c12",      1, 0, 1, 0, 0, 3'b100, 1, 2'b00, 8'd0));
    tbl.push_back(mk("por_c15",      3, 0, 1, 0, 0, 3'b100, 1, 2'b00, 8'd0));
    tbl.push_back(mk("por_c16",      1, 0, 1, 0, 0, 3'b000, 0, 2'b00, 8'd0));
    tbl.push_back(mk("por_run",      5, 0, 1, 0, 0, 3'b000, 0, 2'b00, 8'd0));
    tbl.push_back(mk("sw_pulse",     1, 0, 1, 1, 0, 3'b111, 1, 2'b10, 8'd1));
    tbl.push_back(mk("sw_c7",        7, 0, 1, 0, 0, 3'b111, 1, 2'b10, 8'd1));
    tbl.push_back(mk("sw_c8",        1, 0, 1, 0, 0, 3'b110, 1, 2'b10, 8'd1));
    tbl.push_back(mk("sw_c12",       4, 0, 1, 0, 0, 3'b100, 1, 2'b10, 8'd1));
    tbl.push_back(mk("sw_c15",       3, 0, 1, 0, 0, 3'b100, 1, 2'b10, 8'd1));
    tbl.push_back(mk("sw_c16",       1, 0, 1, 0, 0, 3'b000, 0, 2'b10, 8'd1));
    tbl.push_back(mk("sw_run",       3, 0, 1, 0, 0, 3'b000, 0, 2'b10, 8'd1));
    tbl.push_back(mk("wdt_sw",       1, 0, 1, 1, 1, 3'b111, 1, 2'b11, 8'd2));
    tbl.push_back(mk("assert_c5",    5, 0, 1, 0, 0, 3'b111, 1, 2'b11, 8'd2));
    tbl.push_back(mk("sw_restart",   1, 0, 1, 1, 0, 3'b111, 1, 2'b11, 8'd2));
    tbl.push_back(mk("restart_c7",   7, 0, 1, 0, 0, 3'b111, 1, 2'b11, 8'd2));
    tbl.push_back(mk("restart_c8",   1, 0, 1, 0, 0, 3'b110, 1, 2'b11, 8'd2));
    tbl.push_back(mk("restart_c12",  4, 0, 1, 0, 0, 3'b100, 1, 2'b11, 8'd2));
    tbl.push_back(mk("restart_c16",  4, 0, 1, 0, 0, 3'b000, 0, 2'b11, 8'd2));
    tbl.push_back(mk("glitch_lo",    3, 0, 0, 0, 0, 3'b000, 0, 2'b11, 8'd2));
    tbl.push_back(mk("glitch_hi",   10, 0, 1, 0, 0, 3'b000, 0, 2'b11, 8'd2));
    tbl.push_back(mk("pin_e6",       6, 0, 0, 0, 0, 3'b000, 0, 2'b11, 8'd2));
    tbl.push_back(mk("pin_e7",       1, 0, 0, 0, 0, 3'b111, 1, 2'b01, 8'd3));
    tbl.push_back(mk("pin_e20",     13, 0, 0, 0, 0, 3'b111, 1, 2'b01, 8'd3));
    tbl.push_back(mk("pin_e33",     13, 0, 1, 0, 0, 3'b111, 1, 2'b01, 8'd3));
    tbl.push_back(mk("pin_e34",      1, 0, 1, 0, 0, 3'b110, 1, 2'b01, 8'd3));
    tbl.push_back(mk("pin_e38",      4, 0, 1, 0, 0, 3'b100, 1, 2'b01, 8'd3));
    tbl.push_back(mk("pin_e42",      4, 0, 1, 0, 0, 3'b000, 0, 2'b01, 8'd3));

    reset = 1'b1; nreset_pin = 1'b1; sw_reset_req = 1'b0; wdt_expire = 1'b0;
    #1;
    foreach (tbl[i]) begin
      reset        = tbl[i].rst;
      nreset_pin   = tbl[i].pin;
      sw_reset_req = tbl[i].sw;
      wdt_expire   = tbl[i].wdt;
      step(tbl[i].n);
      chk_all(tbl[i].name, tbl[i].eo, tbl[i].ea, tbl[i].ec, tbl[i].en);
    end
    sw_reset_req = 1'b0; wdt_expire = 1'b0; nreset_pin = 1'b1;

    // Synchronous reset in the middle of a release sequence
    sw_reset_req = 1'b1; step(1); sw_reset_req = 1'b0;
    chk_all("mid_sw", 3'b111, 1'b1, 2'b10, 8'd4);
    step(9);
    chk({"mid_release", ".rst_out"}, {5'd0, rst_out}, 8'b0000_0110);
    reset = 1'b1; step(1);
    chk_all("mid_reset", 3'b111, 1'b1, 2'b00, 8'd0);
    reset = 1'b0; step(7);
    chk_all("mid_c7", 3'b111, 1'b1, 2'b00, 8'd0);
    step(1);
    chk_all("mid_c8", 3'b110, 1'b1, 2'b00, 8'd0);
    step(8);
    chk_all("mid_c16", 3'b000, 1'b0, 2'b00, 8'd0);

    // Saturation: each request lands in RELEASE so every one counts
    for (int i = 0; i < 300; i++) begin
      sw_reset_req = 1'b1; step(1); sw_reset_req = 1'b0;
      if (i == 0) chk("sat_first", reset_count, 8'd1);
      if (i == 254) chk("sat_255", reset_count, 8'd255);
      step(8);
    end
    chk_all("sat_release", 3'b110, 1'b1, 2'b10, 8'd255);
    step(8);
    chk_all("sat_run", 3'b000, 1'b0, 2'b10, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
